uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
Round-robin scheduler that shares one uart_tx transmitter between NUM_REQ first-word-fall-through TX FIFOs.
- Sequences pop -> load -> wait-busy -> wait-done for each word.
- Limits each grant to MAX_BURST words.
- Sits between the per-channel FIFOs and uart_tx.
- Enable, mask and status map onto GPMC register bits in top.

Parameters:
- NUM_REQ, 4, number of requesting FIFOs (2..8).
- DATA_WIDTH, 16, word width passed to uart_tx.
- MAX_BURST, 8, max words sent per grant before rotating (1..255).
- ACK_TIMEOUT, 4, cycles to wait for tx_busy to rise after a load.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-low
- enable  in  1  1 = grants allowed
- req_mask  in  NUM_REQ  1 = requester excluded from arbitration
- req_empty  in  NUM_REQ  FIFO empty flags
- req_data  in  NUM_REQ*DATA_WIDTH  FIFO head words, FWFT; requester i at [i*DATA_WIDTH +: DATA_WIDTH]
- req_rd_en  out  NUM_REQ  one-hot pop strobe
- tx_data  out  DATA_WIDTH  word to uart_tx, registered
- tx_wr_en  out  1  one-cycle load strobe to uart_tx
- tx_busy  in  1  uart_tx busy
- grant_id  out  clog2(NUM_REQ)  current/last granted requester
- active  out  1  1 while a grant is held
- ack_err  out  1  sticky; set on ACK_TIMEOUT expiry, cleared by reset only
- words_sent  out  16  total words loaded, wraps at 0xFFFF->0

Behaviour:
- Reset (async, rst=0): state IDLE; req_rd_en=0, tx_wr_en=0, tx_data=0, grant_id=0, active=0, ack_err=0, words_sent=0, burst_cnt=0, rr pointer=0. Everything else is synchronous to posedge clk.
- Eligible(i) = !req_empty[i] && !req_mask[i].
- FSM states: IDLE, ARB, POP, LOAD, WAIT_ACK, WAIT_DONE.
- IDLE -> ARB when enable=1 and any eligible.
- ARB (1 cycle): pick the first eligible index searching from rr pointer upward, modulo NUM_REQ.
  - On a pick: grant_id<=index, active<=1, burst_cnt<=0 -> POP.
  - If none is eligible, which is possible because flags are re-sampled: -> IDLE.
- POP (1 cycle): tx_data<=req_data[grant_id]; req_rd_en[grant_id]=1 -> LOAD.
- LOAD (1 cycle): tx_wr_en=1; words_sent+=1; burst_cnt+=1 -> WAIT_ACK.
- WAIT_ACK: wait for tx_busy=1 -> WAIT_DONE.
  - If tx_busy is still 0 after ACK_TIMEOUT cycles: set ack_err and go to WAIT_DONE anyway. The word counts as sent.
- WAIT_DONE: wait for tx_busy=0, then:
  - enable=1, eligible(grant_id), burst_cnt<MAX_BURST -> POP (same grant, no re-arbitration).
  - otherwise: rr pointer<=grant_id+1 mod NUM_REQ, active<=0 -> ARB if enable=1, else IDLE.
- Latency from IDLE with an eligible requester to tx_wr_en: ARB+POP+LOAD = tx_wr_en high in the 3rd cycle after entry to ARB.
- Minimum spacing between consecutive tx_wr_en pulses in a burst = POP + LOAD + uart frame time.
- Exactly one req_rd_en pulse per tx_wr_en pulse, always in the preceding cycle.
- enable deasserted mid-word: the current word completes (POP/LOAD/WAIT states run to completion), then IDLE. A pop is never abandoned.
- Mask set on the granted requester mid-burst: the current word completes, then rotate.
- Requester goes empty mid-burst: rotate after the current word; the burst is not padded.
- Simultaneous requests: the rr pointer guarantees fairness. No requester waits more than (NUM_REQ-1)*MAX_BURST words.
- rst asserted mid-frame: all outputs return to reset values immediately. uart_tx reset is owned by top.
- NUM_REQ=1: degenerates to burst-limited pass-through. The rr pointer stays 0.

Decomposition:
- Shared package uart_pkg:
  - FSM state encoding (localparams ST_IDLE..ST_WAIT_DONE, 3 bits).
  - UART_DATA_WIDTH default.
  - clog2 helper function.
- One sub-module: rr_pick, combinational.
  - Inputs: eligible vector, pointer.
  - Outputs: index, valid.
  - Reusable for future RX/DMA arbitration.

Test Plan:
- Single requester 0 with 3 words (0x0041, 0x0042, 0x0043), uart model busy 10 cycles after each load -> tx_data sequence 41,42,43; exactly 3 req_rd_en[0] pulses; words_sent=3; active drops after the third tx_busy fall.
- All 4 requesters full (20 words each), MAX_BURST=8 -> grant order 0,1,2,3,0,...; bursts of exactly 8 words; grant_id never repeats consecutively.
- req_mask=4'b0010 with all 4 requesters non-empty -> requester 1 never granted; after the mask is cleared mid-run, 1 is served on the next rotation that reaches it.
- Uart model that never raises tx_busy, ACK_TIMEOUT=4 -> ack_err=1 exactly 4 cycles after tx_wr_en; FSM still advances to the next word.
- enable dropped in WAIT_ACK of a burst -> current word completes; then no further req_rd_en or tx_wr_en pulses; state IDLE; active=0.
- rst pulsed low in WAIT_DONE -> tx_wr_en, req_rd_en, active, words_sent read 0 on the same edge without waiting for clk. After release, arbitration restarts from requester 0.

Source files
------------

// File: rtl/uart_pkg.sv
// ----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmit-side arbitration logic:
//   - default UART word width
//   - 3-bit FSM state encoding used by uart_tx_arbiter
//   - clog2 helper for sizing index and counter fields
// ----------------------------------------------------------------------------
package uart_pkg;

    localparam int UART_DATA_WIDTH = 16;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_ARB       = 3'd1;
    localparam logic [2:0] ST_POP       = 3'd2;
    localparam logic [2:0] ST_LOAD      = 3'd3;
    localparam logic [2:0] ST_WAIT_ACK  = 3'd4;
    localparam logic [2:0] ST_WAIT_DONE = 3'd5;

    // Number of bits needed to encode values 0..value-1 (0 for value <= 1).
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// ----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin picker: returns the first set bit of i_eligible
// searching upward from i_ptr, wrapping modulo N.
//   i_eligible [N]  candidate vector
//   i_ptr      [W]  search start index (must be < N)
//   o_index    [W]  selected index (0 when nothing is eligible)
//   o_valid         at least one candidate is eligible
// ----------------------------------------------------------------------------
module rr_pick
    import uart_pkg::*;
#(
    parameter int N = 4,
    parameter int W = (N > 1) ? clog2(N) : 1
) (
    input  logic [N-1:0] i_eligible,
    input  logic [W-1:0] i_ptr,
    output logic [W-1:0] o_index,
    output logic         o_valid
);

    logic [W-1:0] w_hi_idx;
    logic [W-1:0] w_lo_idx;
    logic         w_hi_valid;

    // Scan downward so the last hit is the lowest index. The "hi" candidate
    // is the lowest eligible index at or above the pointer; the "lo" one is
    // the lowest overall, used when the search has to wrap.
    always_comb begin
        w_hi_idx   = '0;
        w_lo_idx   = '0;
        w_hi_valid = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (i_eligible[i]) begin
                w_lo_idx = W'(i);
                if (i >= int'(i_ptr)) begin
                    w_hi_idx   = W'(i);
                    w_hi_valid = 1'b1;
                end
            end
        end
    end

    assign o_index = w_hi_valid ? w_hi_idx : w_lo_idx;
    assign o_valid = |i_eligible;

endmodule

// File: rtl/uart_tx_arbiter.sv
// ----------------------------------------------------------------------------
// uart_tx_arbiter
// Shares one uart_tx between NUM_REQ first-word-fall-through TX FIFOs.
// Each word is sequenced pop -> load -> wait-busy -> wait-done; a grant is
// held for at most MAX_BURST words before the round-robin pointer moves on.
//
// Ports:
//   i_clk, i_rst_n       system clock, async active-low reset
//   i_enable             1 = new grants / words allowed
//   i_req_mask   [N]     1 = requester excluded from arbitration
//   i_req_empty  [N]     FIFO empty flags
//   i_req_data   [N*DW]  FIFO head words, requester i at [i*DW +: DW]
//   o_req_rd_en  [N]     one-hot pop strobe
//   o_tx_data    [DW]    word to uart_tx (registered)
//   o_tx_wr_en           one-cycle load strobe to uart_tx
//   i_tx_busy            uart_tx busy
//   o_grant_id           current/last granted requester
//   o_active             1 while a grant is held
//   o_ack_err            sticky: uart_tx never went busy after a load
//   o_words_sent [16]    total words loaded, wrapping
//
// state      | meaning
// -----------+----------------------------------------------------------
// IDLE       | no grant; waiting for enable and an eligible requester
// ARB        | one cycle: pick next requester from the rr pointer
// POP        | capture FIFO head into tx_data, strobe the FIFO pop
// LOAD       | strobe tx_wr_en, count the word, arm the ack timer
// WAIT_ACK   | wait for tx_busy to rise (bounded by ACK_TIMEOUT cycles)
// WAIT_DONE  | wait for tx_busy to fall, then continue burst or rotate
// ----------------------------------------------------------------------------
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter  int NUM_REQ     = 4,
    parameter  int DATA_WIDTH  = UART_DATA_WIDTH,
    parameter  int MAX_BURST   = 8,
    parameter  int ACK_TIMEOUT = 4,
    localparam int GID_W       = (NUM_REQ > 1) ? clog2(NUM_REQ) : 1,
    localparam int ACK_W       = clog2(ACK_TIMEOUT + 1)
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic                          i_enable,
    input  logic [NUM_REQ-1:0]            i_req_mask,
    input  logic [NUM_REQ-1:0]            i_req_empty,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_data,
    output logic [NUM_REQ-1:0]            o_req_rd_en,
    output logic [DATA_WIDTH-1:0]         o_tx_data,
    output logic                          o_tx_wr_en,
    input  logic                          i_tx_busy,
    output logic [GID_W-1:0]              o_grant_id,
    output logic                          o_active,
    output logic                          o_ack_err,
    output logic [15:0]                   o_words_sent
);

    logic [2:0]            r_state;
    logic [GID_W-1:0]      r_rr_ptr;
    logic [GID_W-1:0]      r_grant_id;
    logic [7:0]            r_burst_cnt;
    logic [ACK_W-1:0]      r_ack_cnt;
    logic                  r_active;
    logic                  r_ack_err;
    logic [15:0]           r_words_sent;
    logic [DATA_WIDTH-1:0] r_tx_data;

    logic [NUM_REQ-1:0]    w_eligible;
    logic [GID_W-1:0]      w_pick_idx;
    logic                  w_pick_valid;
    logic [DATA_WIDTH-1:0] w_head;
    logic                  w_grant_elig;
    logic [GID_W-1:0]      w_next_ptr;
    logic                  w_burst_more;

    assign w_eligible = ~i_req_empty & ~i_req_mask;

    rr_pick #(
        .N (NUM_REQ),
        .W (GID_W)
    ) u_rr_pick (
        .i_eligible (w_eligible),
        .i_ptr      (r_rr_ptr),
        .o_index    (w_pick_idx),
        .o_valid    (w_pick_valid)
    );

    always_comb begin
        w_head       = '0;
        w_grant_elig = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (r_grant_id == GID_W'(i)) begin
                w_head       = i_req_data[i*DATA_WIDTH +: DATA_WIDTH];
                w_grant_elig = w_eligible[i];
            end
        end
    end

    assign w_next_ptr   = (r_grant_id == GID_W'(NUM_REQ - 1)) ? '0 : r_grant_id + 1'b1;
    assign w_burst_more = (r_burst_cnt < 8'(MAX_BURST));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= ST_IDLE;
            r_rr_ptr     <= '0;
            r_grant_id   <= '0;
            r_burst_cnt  <= '0;
            r_ack_cnt    <= '0;
            r_active     <= 1'b0;
            r_ack_err    <= 1'b0;
            r_words_sent <= '0;
            r_tx_data    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_enable && (|w_eligible)) begin
                        r_state <= ST_ARB;
                    end
                end
                ST_ARB: begin
                    // Flags are re-sampled here, so the candidate seen in
                    // IDLE may have gone away.
                    if (w_pick_valid) begin
                        r_grant_id  <= w_pick_idx;
                        r_active    <= 1'b1;
                        r_burst_cnt <= '0;
                        r_state     <= ST_POP;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_POP: begin
                    r_tx_data <= w_head;
                    r_state   <= ST_LOAD;
                end
                ST_LOAD: begin
                    r_words_sent <= r_words_sent + 16'd1;
                    r_burst_cnt  <= r_burst_cnt + 8'd1;
                    r_ack_cnt    <= ACK_W'(ACK_TIMEOUT - 1);
                    r_state      <= ST_WAIT_ACK;
                end
                ST_WAIT_ACK: begin
                    if (i_tx_busy) begin
                        r_state <= ST_WAIT_DONE;
                    end else if (r_ack_cnt == '0) begin
                        // Word is still counted as sent; just flag it.
                        r_ack_err <= 1'b1;
                        r_state   <= ST_WAIT_DONE;
                    end else begin
                        r_ack_cnt <= r_ack_cnt - 1'b1;
                    end
                end
                ST_WAIT_DONE: begin
                    if (!i_tx_busy) begin
                        if (i_enable && w_grant_elig && w_burst_more) begin
                            r_state <= ST_POP;
                        end else begin
                            r_rr_ptr <= w_next_ptr;
                            r_active <= 1'b0;
                            r_state  <= i_enable ? ST_ARB : ST_IDLE;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Strobes decode straight from the state register so they clear the
    // instant reset asserts and pair POP/LOAD cycle for cycle.
    always_comb begin
        o_req_rd_en = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            o_req_rd_en[i] = (r_state == ST_POP) && (r_grant_id == GID_W'(i));
        end
    end

    assign o_tx_wr_en   = (r_state == ST_LOAD);
    assign o_tx_data    = r_tx_data;
    assign o_grant_id   = r_grant_id;
    assign o_active     = r_active;
    assign o_ack_err    = r_ack_err;
    assign o_words_sent = r_words_sent;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// ----------------------------------------------------------------------------
// tb_uart_tx_arbiter
// Directed bench for uart_tx_arbiter with 4 FWFT FIFO models and a simple
// uart_tx model that stays busy for 10 cycles after each load.
// ----------------------------------------------------------------------------
module tb_uart_tx_arbiter;

    localparam int N  = 4;
    localparam int DW = 16;

    logic          clk;
    logic          rst_n;
    logic          enable;
    logic [N-1:0]  req_mask;
    logic [N-1:0]  req_empty;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]  req_rd_en;
    logic [DW-1:0] tx_data;
    logic          tx_wr_en;
    logic          tx_busy;
    logic [1:0]    grant_id;
    logic          active;
    logic          ack_err;
    logic [15:0]   words_sent;

    uart_tx_arbiter #(
        .NUM_REQ     (N),
        .DATA_WIDTH  (DW),
        .MAX_BURST   (8),
        .ACK_TIMEOUT (4)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_enable     (enable),
        .i_req_mask   (req_mask),
        .i_req_empty  (req_empty),
        .i_req_data   (req_data),
        .o_req_rd_en  (req_rd_en),
        .o_tx_data    (tx_data),
        .o_tx_wr_en   (tx_wr_en),
        .i_tx_busy    (tx_busy),
        .o_grant_id   (grant_id),
        .o_active     (active),
        .o_ack_err    (ack_err),
        .o_words_sent (words_sent)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // FIFO models: mem/wp written by the stimulus, rp advanced by pops.
    logic [DW-1:0] mem [N][256];
    int            wp [N];
    int            rp [N];

    always_comb begin
        for (int i = 0; i < N; i++) begin
            req_empty[i]           = (rp[i] == wp[i]);
            req_data[i*DW +: DW]   = mem[i][rp[i] & 255];
        end
    end

    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (req_rd_en[i]) rp[i] <= rp[i] + 1;
        end
    end

    // uart_tx model
    logic uart_on;
    int   busy_cnt;
    always @(posedge clk) begin
        if (uart_on && tx_wr_en) busy_cnt <= 10;
        else if (busy_cnt > 0)   busy_cnt <= busy_cnt - 1;
    end
    assign tx_busy = (busy_cnt > 0);

    // Event log, sampled at posedge with pre-edge values.
    logic [DW-1:0] wr_data [512];
    int            wr_gid  [512];
    logic [N-1:0]  wr_prev [512];
    int            n_wr;
    int            rd_cnt [N];
    logic [N-1:0]  last_rd;

    always @(posedge clk) begin
        if (tx_wr_en && n_wr < 512) begin
            wr_data[n_wr] = tx_data;
            wr_gid[n_wr]  = int'(grant_id);
            wr_prev[n_wr] = last_rd;
            n_wr = n_wr + 1;
        end
        for (int i = 0; i < N; i++) begin
            if (req_rd_en[i]) rd_cnt[i] = rd_cnt[i] + 1;
        end
        last_rd = req_rd_en;
    end

    int n_chk;
    int n_bad;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk = n_chk + 1;
        if (got !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic push(input int ch, input logic [DW-1:0] d);
        mem[ch][wp[ch] & 255] = d;
        wp[ch] = wp[ch] + 1;
    endtask

    task automatic flush_all();
        for (int i = 0; i < N; i++) wp[i] = rp[i];
    endtask

    task automatic do_reset();
        @(negedge clk);
        enable = 1'b0;
        rst_n  = 1'b0;
        repeat (3) @(negedge clk);
        rst_n  = 1'b1;
    endtask

    task automatic wait_wr(input int target, input int budget, input string tag);
        int t;
        t = 0;
        while (n_wr < target && t < budget) begin
            @(negedge clk);
            t++;
        end
        chk({tag, "_wr_timeout"}, 32'(n_wr >= target), 32'd1);
    endtask

    task automatic wait_strobe(input int budget, input string tag);
        int t;
        t = 0;
        while (!tx_wr_en && t < budget) begin
            @(negedge clk);
            t++;
        end
        chk({tag, "_strobe_timeout"}, 32'(tx_wr_en), 32'd1);
    endtask

    task automatic wait_inactive(input int budget, input string tag);
        int t;
        t = 0;
        while (active && t < budget) begin
            @(negedge clk);
            t++;
        end
        chk({tag, "_active"}, 32'(active), 32'd0);
    endtask

    int base;
    int rd_base;
    int k;
    int exp_gid;
    logic [DW-1:0] exp_d;

    initial begin
        n_chk = 0; n_bad = 0; n_wr = 0; last_rd = '0;
        for (int i = 0; i < N; i++) begin wp[i] = 0; rp[i] = 0; rd_cnt[i] = 0; end
        busy_cnt = 0;
        uart_on  = 1'b1;
        rst_n    = 1'b0;
        enable   = 1'b0;
        req_mask = '0;

        // Reset values
        repeat (2) @(negedge clk);
        chk("rst_wr_en",  32'(tx_wr_en),   32'd0);
        chk("rst_rd_en",  32'(req_rd_en),  32'd0);
        chk("rst_data",   32'(tx_data),    32'd0);
        chk("rst_gid",    32'(grant_id),   32'd0);
        chk("rst_active", 32'(active),     32'd0);
        chk("rst_ackerr", 32'(ack_err),    32'd0);
        chk("rst_words",  32'(words_sent), 32'd0);
        rst_n = 1'b1;

        // T1: single requester, 3 words, latency from IDLE
        @(negedge clk);
        push(0, 16'h0041); push(0, 16'h0042); push(0, 16'h0043);
        base = n_wr; rd_base = rd_cnt[0];
        enable = 1'b1;
        @(negedge clk);
        chk("t1_arb_no_wr", 32'(tx_wr_en), 32'd0);
        @(negedge clk);
        chk("t1_pop_rd", 32'(req_rd_en), 32'b0001);
        @(negedge clk);
        chk("t1_load_wr", 32'(tx_wr_en), 32'd1);
        chk("t1_load_data", 32'(tx_data), 32'h41);
        wait_wr(base + 3, 200, "t1");
        wait_inactive(100, "t1");
        chk("t1_busy_at_drop", 32'(tx_busy), 32'd0);
        for (int i = 0; i < 3; i++) begin
            chk("t1_data", 32'(wr_data[base+i]), 32'h41 + 32'(i));
            chk("t1_prev_rd", 32'(wr_prev[base+i]), 32'b0001);
        end
        chk("t1_rd_pulses", 32'(rd_cnt[0] - rd_base), 32'd3);
        chk("t1_words", 32'(words_sent), 32'd3);
        chk("t1_nwr", 32'(n_wr - base), 32'd3);

        // T2: all four full, bursts of 8
        do_reset();
        for (int c = 0; c < N; c++)
            for (int j = 0; j < 20; j++) push(c, DW'((c << 8) | j));
        base = n_wr;
        enable = 1'b1;
        wait_wr(base + 80, 3000, "t2");
        wait_inactive(200, "t2");
        k = base;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < N; c++) begin
                for (int j = 0; j < ((r < 2) ? 8 : 4); j++) begin
                    exp_d = DW'((c << 8) | (r * 8 + j));
                    chk("t2_gid",  32'(wr_gid[k]),  32'(c));
                    chk("t2_data", 32'(wr_data[k]), 32'(exp_d));
                    chk("t2_prev_rd", 32'(wr_prev[k]), 32'(1 << c));
                    k++;
                end
            end
        end
        chk("t2_words", 32'(words_sent), 32'd80);

        // T3: requester 1 masked, unmasked mid-run
        do_reset();
        req_mask = 4'b0010;
        for (int c = 0; c < N; c++)
            for (int j = 0; j < 6; j++) push(c, DW'(16'h1000 | (c << 8) | j));
        base = n_wr;
        enable = 1'b1;
        wait_wr(base + 9, 600, "t3a");
        req_mask = 4'b0000;
        wait_wr(base + 24, 1200, "t3b");
        wait_inactive(200, "t3");
        for (int i = 0; i < 24; i++) begin
            exp_gid = (i < 6) ? 0 : (i < 12) ? 2 : (i < 18) ? 3 : 1;
            chk("t3_gid",  32'(wr_gid[base+i]),  32'(exp_gid));
            chk("t3_data", 32'(wr_data[base+i]), 32'(16'h1000 | (exp_gid << 8) | (i % 6)));
        end

        // T4: uart never goes busy -> ack timeout
        do_reset();
        uart_on = 1'b0;
        push(0, 16'h00A1); push(0, 16'h00A2);
        base = n_wr;
        enable = 1'b1;
        wait_strobe(50, "t4");
        repeat (4) @(negedge clk);
        chk("t4_ackerr_early", 32'(ack_err), 32'd0);
        @(negedge clk);
        chk("t4_ackerr_set", 32'(ack_err), 32'd1);
        wait_wr(base + 2, 200, "t4");
        wait_inactive(100, "t4");
        chk("t4_ackerr_sticky", 32'(ack_err), 32'd1);
        chk("t4_words", 32'(words_sent), 32'd2);
        chk("t4_data2", 32'(wr_data[base+1]), 32'h00A2);
        uart_on = 1'b1;

        // T5: enable dropped in WAIT_ACK
        do_reset();
        for (int j = 0; j < 5; j++) push(0, DW'(16'h0050 + j));
        base = n_wr; rd_base = rd_cnt[0];
        enable = 1'b1;
        wait_strobe(50, "t5");
        @(negedge clk);
        enable = 1'b0;
        repeat (40) @(negedge clk);
        chk("t5_nwr", 32'(n_wr - base), 32'd1);
        chk("t5_rd_pulses", 32'(rd_cnt[0] - rd_base), 32'd1);
        chk("t5_active", 32'(active), 32'd0);
        chk("t5_left", 32'(wp[0] - rp[0]), 32'd4);
        chk("t5_words", 32'(words_sent), 32'd1);
        flush_all();

        // T6: reset in WAIT_DONE; rr pointer was 1 before reset
        @(negedge clk);
        for (int j = 0; j < 4; j++) push(2, DW'(16'h0260 + j));
        enable = 1'b1;
        wait_strobe(50, "t6a");
        chk("t6_pre_gid", 32'(grant_id), 32'd2);
        repeat (3) @(negedge clk);
        chk("t6_pre_busy", 32'(tx_busy), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("t6_rst_wr_en",  32'(tx_wr_en),   32'd0);
        chk("t6_rst_rd_en",  32'(req_rd_en),  32'd0);
        chk("t6_rst_active", 32'(active),     32'd0);
        chk("t6_rst_words",  32'(words_sent), 32'd0);
        chk("t6_rst_data",   32'(tx_data),    32'd0);
        push(0, 16'h0070); push(0, 16'h0071);
        repeat (12) @(negedge clk);
        rst_n = 1'b1;
        wait_strobe(50, "t6b");
        chk("t6_restart_gid",  32'(grant_id), 32'd0);
        chk("t6_restart_data", 32'(tx_data),  32'h0070);
        enable = 1'b0;
        repeat (40) @(negedge clk);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
